synch_filt: RTL and testbench
=============================

SYNCH_FILT -- requirements
Module: synch_filt

Interface
REQ-001 The module SHALL expose parameter K, default 8, giving the channel count and bus width.
REQ-002 The module SHALL expose parameter STAGES, default 2, giving the synchroniser depth; legal range 2..4.
REQ-003 The module SHALL expose parameter FILT, default 0, giving the stability filter length in cycles; 0 means bypass, legal range 0..255.
REQ-004 The module SHALL expose parameter RST_VAL, default {K{1'b0}}, giving the per-channel reset value.
REQ-005 syn_clk  input  1  single clock; all state is clocked on its rising edge.
REQ-006 syn_rst_n  input  1  asynchronous, active-low reset.
REQ-007 in  input  K  asynchronous level inputs, one per channel.
REQ-008 syn_out  output  K  synchronised, filtered levels.
REQ-009 rise  output  K  one-cycle pulse per channel on a 0->1 change of syn_out.
REQ-010 fall  output  K  one-cycle pulse per channel on a 1->0 change of syn_out.
REQ-011 chg  output  1  OR of all rise and fall bits.

Function
REQ-012 in SHALL pass through a STAGES-deep flop chain per channel (sync_q = last stage), and every chain flop SHALL carry ASYNC_REG="TRUE".
REQ-013 With FILT=0, syn_out SHALL equal sync_q, and latency from the sampling edge to syn_out SHALL be STAGES cycles.
REQ-014 With FILT>0, each channel SHALL hold a counter of width clog2(FILT+1) and a held level filt_q, with syn_out=filt_q.
REQ-015 Each cycle with sync_q!=filt_q SHALL increment the counter; on the cycle the counter equals FILT-1, filt_q SHALL load sync_q and the counter SHALL clear.
REQ-016 Any cycle with sync_q==filt_q SHALL clear the counter, so a glitch shorter than FILT cycles never reaches syn_out.
REQ-017 With FILT>0, a held step SHALL reach syn_out exactly STAGES+FILT cycles after the sampling edge.
REQ-018 The counter SHALL never exceed FILT-1, and no wrap-around SHALL occur.
REQ-019 Each channel SHALL keep a prev_q register loaded from syn_out every cycle.
REQ-020 Edge outputs SHALL be registered as rise<=syn_out&~prev_q and fall<=~syn_out&prev_q, so each pulse is asserted one cycle after syn_out changes and lasts exactly one cycle.
REQ-021 chg SHALL be combinational from the registered rise and fall.
REQ-022 Channels SHALL be fully independent, and simultaneous changes on several channels SHALL each produce their own pulses in the same cycle.
REQ-023 A toggle on a channel while its filter is counting in the opposite direction SHALL restart that channel's qualification per REQ-015 and REQ-016.

Reset
REQ-024 While syn_rst_n=0, all chain flops, filt_q and prev_q SHALL be forced to RST_VAL immediately (asynchronously), and counters, rise and fall SHALL be forced to 0.
REQ-025 Reset values SHALL be: syn_out=RST_VAL, rise=0, fall=0, chg=0.
REQ-026 No rise or fall pulse SHALL be generated by reset assertion, by reset release, or by a reset asserted mid-qualification.
REQ-027 Reset release SHALL be synchronised externally; the block SHALL NOT contain a reset synchroniser.

Structure
REQ-028 Shared package synch_pkg SHALL hold the clog2 function, STAGES_MIN=2, STAGES_MAX=4 and FILT_MAX=255.
REQ-029 Per-channel logic SHALL be the sub-module synch_filt_ch (chain, filter, edge registers), instantiated K times in a generate loop.
REQ-030 Illegal parameter values SHALL trigger an elaboration-time error.

Verification
Unless stated otherwise, scenarios use K=4, STAGES=2, FILT=3, RST_VAL=4'b0101.
REQ-031 Hold syn_rst_n=0 with in=4'b1010, then release -> syn_out=4'b0101 during reset; rise=fall=0 and chg=0 for 10 cycles after release with in held at 4'b0101.
REQ-032 Step in[1] 0->1 and hold -> syn_out[1] rises 5 cycles after the sampling edge; rise[1]=1 for exactly one cycle at +6; chg=1 in the same cycle.
REQ-033 Pulse in[3] high for 2 cycles, then for 3 cycles -> the 2-cycle pulse gives no syn_out change and no pulses; the 3-cycle pulse gives syn_out[3] 0->1 and a later 1->0 with one rise[3] and one fall[3].
REQ-034 Step in[0] 1->0 and in[1] 0->1 on the same edge -> fall[0] and rise[1] are both asserted in the same cycle; chg is a single-cycle pulse.
REQ-035 Assert syn_rst_n mid-cycle while the in[1] counter=2 -> syn_out returns to 4'b0101 without waiting for a clock edge; the counter reads 0; no pulses occur after release.
REQ-036 With FILT=0 and STAGES=3, step in[2] -> syn_out[2] changes exactly 3 cycles after the sampling edge; rise[2] pulses at +4.

Source files
------------

// File: rtl/synch_pkg.sv
// Shared constants and helpers for the level synchroniser / stability filter.
package synch_pkg;

  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;
  localparam int FILT_MAX   = 255;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/synch_filt_ch.sv
// One channel: metastability chain, optional stability filter, and edge-pulse registers.
module synch_filt_ch
  import synch_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter int   FILT    = 0,
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;
  logic sync_q;
  logic filt_level;
  logic prev_q;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= {STAGES{RST_BIT}};
    else        chain <= {chain[STAGES-2:0], din};
  end

  assign sync_q = chain[STAGES-1];

  if (FILT == 0) begin : g_bypass
    assign filt_level = sync_q;
  end else begin : g_filt
    localparam int              CNT_W    = clog2(FILT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT - 1);

    logic [CNT_W-1:0] cnt;
    logic             filt_q;

    // Accept a new level only after it differs from the held level for FILT consecutive cycles;
    // any agreeing cycle restarts qualification, so the counter tops out at FILT-1.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        filt_q <= RST_BIT;
        cnt    <= '0;
      end else if (sync_q == filt_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt_q <= sync_q;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign filt_level = filt_q;
  end

  // Register one-cycle edge pulses; prev_q resets to the same value as the level so
  // neither reset entry nor release can look like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= RST_BIT;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      prev_q <= filt_level;
      rise   <= filt_level & ~prev_q;
      fall   <= ~filt_level & prev_q;
    end
  end

  assign level = filt_level;

endmodule

// File: rtl/synch_filt.sv
// K-channel level synchroniser with optional glitch filter and per-channel edge pulses.
// Reset release is expected to be synchronised to syn_clk outside this block.
module synch_filt
  import synch_pkg::*;
#(
  parameter int           K       = 8,
  parameter int           STAGES  = 2,
  parameter int           FILT    = 0,
  parameter logic [K-1:0] RST_VAL = {K{1'b0}}
) (
  input  logic         syn_clk,
  input  logic         syn_rst_n,
  input  logic [K-1:0] in,
  output logic [K-1:0] syn_out,
  output logic [K-1:0] rise,
  output logic [K-1:0] fall,
  output logic         chg
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("synch_filt: STAGES=%0d outside %0d..%0d", STAGES, STAGES_MIN, STAGES_MAX);
  end
  if (FILT < 0 || FILT > FILT_MAX) begin : g_bad_filt
    $error("synch_filt: FILT=%0d outside 0..%0d", FILT, FILT_MAX);
  end
  if (K < 1) begin : g_bad_k
    $error("synch_filt: K=%0d must be at least 1", K);
  end

  for (genvar i = 0; i < K; i++) begin : g_ch
    synch_filt_ch #(
      .STAGES (STAGES),
      .FILT   (FILT),
      .RST_BIT(RST_VAL[i])
    ) u_ch (
      .clk  (syn_clk),
      .rst_n(syn_rst_n),
      .din  (in[i]),
      .level(syn_out[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  assign chg = |{rise, fall};

endmodule

// File: tb/tb_synch_filt.sv
// Scoreboard bench for synch_filt: a filtered instance (STAGES=2, FILT=3) and a bypass
// instance (STAGES=3, FILT=0). Observed vector per cycle is {syn_out, rise, fall, chg}.
module tb_synch_filt;

  localparam logic [3:0] RV = 4'b0101;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in1, in2;
  logic [3:0] so1, r1, f1, so2, r2, f2;
  logic       c1, c2;

  int checks   = 0;
  int failures = 0;

  logic [12:0] exp1_q[$];
  logic [12:0] exp2_q[$];

  always #5 clk = ~clk;

  synch_filt #(.K(4), .STAGES(2), .FILT(3), .RST_VAL(RV)) dut1 (
    .syn_clk(clk), .syn_rst_n(rst_n), .in(in1),
    .syn_out(so1), .rise(r1), .fall(f1), .chg(c1)
  );

  synch_filt #(.K(4), .STAGES(3), .FILT(0), .RST_VAL(RV)) dut2 (
    .syn_clk(clk), .syn_rst_n(rst_n), .in(in2),
    .syn_out(so2), .rise(r2), .fall(f2), .chg(c2)
  );

  function automatic logic [12:0] pk(input logic [3:0] s, input logic [3:0] r,
                                     input logic [3:0] f, input logic c);
    return {s, r, f, c};
  endfunction

  // Reset holds RST_VAL regardless of inputs; release produces no pulses.
  task automatic test_reset();
    logic [12:0] e;
    rst_n = 1'b0;
    in1   = 4'b1010;
    in2   = 4'b1010;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({so1, r1, f1, c1} !== pk(RV, 4'b0, 4'b0, 1'b0)) begin
      failures++;
      $display("FAIL reset_hold_filt got=%b exp=%b", {so1, r1, f1, c1}, pk(RV, 4'b0, 4'b0, 1'b0));
    end
    checks++;
    if ({so2, r2, f2, c2} !== pk(RV, 4'b0, 4'b0, 1'b0)) begin
      failures++;
      $display("FAIL reset_hold_bypass got=%b exp=%b", {so2, r2, f2, c2}, pk(RV, 4'b0, 4'b0, 1'b0));
    end
    in1 = RV;
    in2 = RV;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp1_q.push_back(pk(RV, 4'b0, 4'b0, 1'b0));
      exp2_q.push_back(pk(RV, 4'b0, 4'b0, 1'b0));
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      e = exp1_q.pop_front();
      checks++;
      if ({so1, r1, f1, c1} !== e) begin
        failures++;
        $display("FAIL reset_release_filt cyc=%0d got=%b exp=%b", k, {so1, r1, f1, c1}, e);
      end
      e = exp2_q.pop_front();
      checks++;
      if ({so2, r2, f2, c2} !== e) begin
        failures++;
        $display("FAIL reset_release_bypass cyc=%0d got=%b exp=%b", k, {so2, r2, f2, c2}, e);
      end
    end
  endtask

  // in[0] falls and in[1] rises on the same edge, then both revert.
  task automatic test_simultaneous();
    logic [12:0] e;
    logic [3:0]  nv, ov;
    for (int ph = 0; ph < 2; ph++) begin
      ov = (ph == 0) ? RV : 4'b0110;
      nv = (ph == 0) ? 4'b0110 : RV;
      for (int k = 0; k < 8; k++) begin
        exp1_q.push_back(pk((k >= 4) ? nv : ov,
                            (k == 5) ? (nv & ~ov) : 4'b0,
                            (k == 5) ? (ov & ~nv) : 4'b0,
                            (k == 5)));
      end
      in1 = nv;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk);
        #1;
        e = exp1_q.pop_front();
        checks++;
        if ({so1, r1, f1, c1} !== e) begin
          failures++;
          $display("FAIL simultaneous ph=%0d cyc=%0d got=%b exp=%b", ph, k, {so1, r1, f1, c1}, e);
        end
      end
    end
  endtask

  // Held step on in[1]: syn_out at +5, rise at +6.
  task automatic test_step();
    logic [12:0] e;
    for (int k = 0; k < 9; k++) begin
      exp1_q.push_back(pk((k >= 4) ? 4'b0111 : 4'b0101,
                          (k == 5) ? 4'b0010 : 4'b0, 4'b0, (k == 5)));
    end
    in1 = 4'b0111;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      e = exp1_q.pop_front();
      checks++;
      if ({so1, r1, f1, c1} !== e) begin
        failures++;
        $display("FAIL step cyc=%0d got=%b exp=%b", k, {so1, r1, f1, c1}, e);
      end
    end
  endtask

  // in[3] 2-cycle pulse is rejected; 3-cycle pulse passes with one rise and one fall.
  task automatic test_glitch();
    logic [12:0] e;
    for (int k = 0; k < 10; k++) exp1_q.push_back(pk(4'b0111, 4'b0, 4'b0, 1'b0));
    for (int k = 0; k < 10; k++) begin
      in1 = (k < 2) ? 4'b1111 : 4'b0111;
      @(posedge clk);
      #1;
      e = exp1_q.pop_front();
      checks++;
      if ({so1, r1, f1, c1} !== e) begin
        failures++;
        $display("FAIL glitch_short cyc=%0d got=%b exp=%b", k, {so1, r1, f1, c1}, e);
      end
    end
    for (int k = 0; k < 12; k++) begin
      exp1_q.push_back(pk((k >= 4 && k <= 6) ? 4'b1111 : 4'b0111,
                          (k == 5) ? 4'b1000 : 4'b0,
                          (k == 8) ? 4'b1000 : 4'b0,
                          (k == 5 || k == 8)));
    end
    for (int k = 0; k < 12; k++) begin
      in1 = (k < 3) ? 4'b1111 : 4'b0111;
      @(posedge clk);
      #1;
      e = exp1_q.pop_front();
      checks++;
      if ({so1, r1, f1, c1} !== e) begin
        failures++;
        $display("FAIL glitch_pass cyc=%0d got=%b exp=%b", k, {so1, r1, f1, c1}, e);
      end
    end
  endtask

  // in[3]: high 2, low 1, high 3 -- the gap restarts qualification so only the
  // second burst is accepted, 3 cycles later than a clean step would be.
  task automatic test_restart();
    logic [12:0] e;
    logic [5:0]  pat;
    pat = 6'b111011;
    for (int k = 0; k < 14; k++) begin
      exp1_q.push_back(pk((k >= 7 && k <= 9) ? 4'b1111 : 4'b0111,
                          (k == 8) ? 4'b1000 : 4'b0,
                          (k == 11) ? 4'b1000 : 4'b0,
                          (k == 8 || k == 11)));
    end
    for (int k = 0; k < 14; k++) begin
      in1 = (k < 6 && pat[k]) ? 4'b1111 : 4'b0111;
      @(posedge clk);
      #1;
      e = exp1_q.pop_front();
      checks++;
      if ({so1, r1, f1, c1} !== e) begin
        failures++;
        $display("FAIL restart cyc=%0d got=%b exp=%b", k, {so1, r1, f1, c1}, e);
      end
    end
  endtask

  // Reset asserted between edges while in[1] is qualifying a fall.
  task automatic test_reset_mid();
    logic [12:0] e;
    for (int k = 0; k < 4; k++) exp1_q.push_back(pk(4'b0111, 4'b0, 4'b0, 1'b0));
    in1 = RV;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      e = exp1_q.pop_front();
      checks++;
      if ({so1, r1, f1, c1} !== e) begin
        failures++;
        $display("FAIL mid_qualify cyc=%0d got=%b exp=%b", k, {so1, r1, f1, c1}, e);
      end
    end
    checks++;
    if (dut1.g_ch[1].u_ch.g_filt.cnt !== 2'd2) begin
      failures++;
      $display("FAIL mid_cnt_before got=%0d exp=2", dut1.g_ch[1].u_ch.g_filt.cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({so1, r1, f1, c1} !== pk(RV, 4'b0, 4'b0, 1'b0)) begin
      failures++;
      $display("FAIL mid_async_reset got=%b exp=%b", {so1, r1, f1, c1}, pk(RV, 4'b0, 4'b0, 1'b0));
    end
    checks++;
    if (dut1.g_ch[1].u_ch.g_filt.cnt !== 2'd0) begin
      failures++;
      $display("FAIL mid_cnt_reset got=%0d exp=0", dut1.g_ch[1].u_ch.g_filt.cnt);
    end
    #2 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) exp1_q.push_back(pk(RV, 4'b0, 4'b0, 1'b0));
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      e = exp1_q.pop_front();
      checks++;
      if ({so1, r1, f1, c1} !== e) begin
        failures++;
        $display("FAIL mid_release cyc=%0d got=%b exp=%b", k, {so1, r1, f1, c1}, e);
      end
    end
  endtask

  // Bypass instance: in[2] falls then rises; syn_out at +3, pulse at +4.
  task automatic test_bypass();
    logic [12:0] e;
    logic [3:0]  nv, ov;
    for (int ph = 0; ph < 2; ph++) begin
      ov = (ph == 0) ? RV : 4'b0001;
      nv = (ph == 0) ? 4'b0001 : RV;
      for (int k = 0; k < 8; k++) begin
        exp2_q.push_back(pk((k >= 2) ? nv : ov,
                            (k == 3) ? (nv & ~ov) : 4'b0,
                            (k == 3) ? (ov & ~nv) : 4'b0,
                            (k == 3)));
      end
      in2 = nv;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk);
        #1;
        e = exp2_q.pop_front();
        checks++;
        if ({so2, r2, f2, c2} !== e) begin
          failures++;
          $display("FAIL bypass ph=%0d cyc=%0d got=%b exp=%b", ph, k, {so2, r2, f2, c2}, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_step();
    test_glitch();
    test_restart();
    test_reset_mid();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
